simple_fpga_cvs: RTL and testbench
==================================

// Module: simple_fpga_cvs
// PURPOSE
// - Top-level board bring-up block. Maps five single-bit inputs to four combinational logic outputs.
// - Derives a 1.5 Hz square wave (LED blink) from the 300 MHz differential board oscillator.
// - Clock is the differential osc_300_pn; reset is synchronous, active-high.
// PARAMETERS
// - CLK_HZ       300_000_000  input oscillator frequency
// - OUT_HZ       1.5 (fixed)  documentation only; the divide is set by HALF_PERIOD
// - HALF_PERIOD  100_000_000  osc cycles per output half-period (CLK_HZ/(2*1.5)); must be >= 1
// - CNT_W        27           counter width; must satisfy 2**CNT_W >= HALF_PERIOD
// PORTS
// - osc_300_pn       in   [1:0] unpacked  300 MHz differential clock; [0]=P, [1]=N; one clock domain
// - reset            in   1   synchronous, active-high; sampled on rising edge of P
// - in               in   [4:0] unpacked  general inputs (switches/buttons)
// - in0_out          out  1   in[0]
// - in0_and_in1_out  out  1   in[0] & in[1]
// - in0_or_in1_out   out  1   in[0] | in[1]
// - not_in2_out      out  1   ~in[2]
// - clk_1point5hz    out  1   registered 50% duty square wave, CLK_HZ/(2*HALF_PERIOD)
// - Declaration order is fixed for positional instantiation:
//   in, in0_out, in0_and_in1_out, in0_or_in1_out, not_in2_out, osc_300_pn, clk_1point5hz, reset.
// - reset is last. When unconnected (z/0), the divider free-runs.
// BEHAVIOUR
// - Logic outputs: purely combinational, zero latency, unaffected by reset.
// - in[3] and in[4] are unused. They must not drive any output.
// - Clock:
//   - core clock = osc_300_pn[0] (rising edge).
//   - In synthesis, osc_300_pn passes through the differential input buffer sub-module.
//   - In simulation, the buffer is a pass-through of [0].
// - Divider:
//   - cnt (CNT_W bits) increments every rising edge.
//   - When cnt == HALF_PERIOD-1: cnt <= 0 and clk_1point5hz <= ~clk_1point5hz.
// - Reset (synchronous): cnt <= 0, clk_1point5hz <= 0.
//   - First toggle to 1 occurs on the HALF_PERIOD-th rising edge after the edge that samples reset low.
// - Period is exactly 2*HALF_PERIOD clock cycles. With defaults: 200_000_000 cycles, 666.67 ms.
// - Reset asserted mid-count: next edge forces cnt=0 and output=0 regardless of phase.
// - Reset held: output stays 0.
// - HALF_PERIOD==1: output toggles every cycle (CLK_HZ/2).
// - No glitches: clk_1point5hz comes directly from a flop. It is a logic signal, not a clock.
// STRUCTURE
// - Package simple_fpga_cvs_pkg:
//   - CLK_HZ, HALF_PERIOD default, CNT_W = $clog2(HALF_PERIOD+1).
//   - localparam N_IN = 5.
// - Sub-modules:
//   - clk_divider: params HALF_PERIOD, CNT_W; ports clk, reset, out.
//   - diff_clk_buf: wraps the vendor differential buffer; behavioural pass-through of P.
// - Top contains only the combinational assigns and the two instantiations.
// TESTING
// - in={0,0,0,0,0} -> in0_out=0, and=0, or=0, not_in2_out=1.
// - Sweep in[2:0] over all 8 values, with in[4:3] random:
//   - outputs match the truth table within the same delta.
//   - in[4:3] changes alone never change any output.
// - HALF_PERIOD=4, reset 3 cycles then release:
//   - out=0 for 4 edges, then 1 for 4, 0 for 4, repeating.
//   - Period is 8 cycles.
// - HALF_PERIOD=4, assert reset while out=1 at cnt=2 -> next edge out=0, cnt=0; after release, 4 more edges to first rise.
// - Defaults, osc period 3333.333 ps -> clk_1point5hz edges 333.33 ms apart (+/- 1 osc period).
//   - Check two edges, with reset tied 0.
// - HALF_PERIOD=1 -> out toggles every rising edge after reset release.

Source files
------------

// File: rtl/simple_fpga_cvs_pkg.sv
// Shared constants for the board bring-up block: oscillator rate and the
// default LED-blink divide.
package simple_fpga_cvs_pkg;

    localparam int CLK_HZ          = 300_000_000;
    localparam int HALF_PERIOD_DEF = 100_000_000;
    localparam int CNT_W_DEF       = $clog2(HALF_PERIOD_DEF + 1);
    localparam int N_IN            = 5;

endpackage

// File: rtl/simple_fpga_cvs_clk_divider.sv
// Square-wave divider: output flips every HALF_PERIOD rising edges, driven
// straight from a flop so it is glitch-free (a logic signal, not a clock).
module clk_divider #(
    parameter int HALF_PERIOD = 100_000_000,
    parameter int CNT_W       = $clog2(HALF_PERIOD + 1)
) (
    input  logic clk,
    input  logic reset,
    output logic out
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (cnt == TERM) begin
            cnt <= '0;
            out <= ~out;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/simple_fpga_cvs_diff_clk_buf.sv
// Differential oscillator input buffer. Behaviourally the core clock is the
// P leg; a vendor primitive replaces this body in implementation.
module diff_clk_buf (
    input  logic clk_p,
    input  logic clk_n,
    output logic clk
);

    logic unused_clk_n;

    assign unused_clk_n = clk_n;
    assign clk          = clk_p;

endmodule

// File: rtl/simple_fpga_cvs.sv
// Board bring-up top: four combinational switch-to-LED mappings plus a slow
// blink derived from the 300 MHz differential oscillator.
module simple_fpga_cvs
    import simple_fpga_cvs_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int CNT_W       = $clog2(HALF_PERIOD + 1)
) (
    input  logic in [N_IN-1:0],
    output logic in0_out,
    output logic in0_and_in1_out,
    output logic in0_or_in1_out,
    output logic not_in2_out,
    input  logic osc_300_pn [1:0],
    output logic clk_1point5hz,
    input  logic reset
);

    logic clk_sys;
    logic unused_in;

    // in[3] and in[4] are spare switches with no function
    assign unused_in       = in[3] ^ in[4];

    assign in0_out         = in[0];
    assign in0_and_in1_out = in[0] & in[1];
    assign in0_or_in1_out  = in[0] | in[1];
    assign not_in2_out     = ~in[2];

    diff_clk_buf u_clk_buf (
        .clk_p (osc_300_pn[0]),
        .clk_n (osc_300_pn[1]),
        .clk   (clk_sys)
    );

    clk_divider #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_div (
        .clk   (clk_sys),
        .reset (reset),
        .out   (clk_1point5hz)
    );

endmodule

// File: tb/tb_simple_fpga_cvs.sv
// Bench for simple_fpga_cvs: logic truth table, spare-input isolation and
// divider waveform on small-divide, divide-by-1 and default instances.
`timescale 1ns/1ps
module tb_simple_fpga_cvs;

    logic clk_p = 1'b0;
    logic osc [1:0];
    logic rst = 1'b1;
    logic in_v [4:0];

    logic o0_a, o_and_a, o_or_a, o_not_a, blink_4;
    logic o0_b, o_and_b, o_or_b, o_not_b, blink_1;
    logic o0_c, o_and_c, o_or_c, o_not_c, blink_def;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_logic_q [$];
    bit         exp4_q [$];
    bit         exp1_q [$];
    int         k4 = 0;
    int         k1 = 0;
    int         cyc = 0;

    assign osc[0] = clk_p;
    assign osc[1] = ~clk_p;

    always #1.667 clk_p = ~clk_p;

    simple_fpga_cvs #(.HALF_PERIOD(4)) dut_h4 (
        .in(in_v), .in0_out(o0_a), .in0_and_in1_out(o_and_a), .in0_or_in1_out(o_or_a),
        .not_in2_out(o_not_a), .osc_300_pn(osc), .clk_1point5hz(blink_4), .reset(rst));

    simple_fpga_cvs #(.HALF_PERIOD(1)) dut_h1 (
        .in(in_v), .in0_out(o0_b), .in0_and_in1_out(o_and_b), .in0_or_in1_out(o_or_b),
        .not_in2_out(o_not_b), .osc_300_pn(osc), .clk_1point5hz(blink_1), .reset(rst));

    simple_fpga_cvs dut_def (
        .in(in_v), .in0_out(o0_c), .in0_and_in1_out(o_and_c), .in0_or_in1_out(o_or_c),
        .not_in2_out(o_not_c), .osc_300_pn(osc), .clk_1point5hz(blink_def), .reset(rst));

    task automatic drive_in(input logic [4:0] v);
        logic [3:0] e;
        for (int i = 0; i < 5; i++) in_v[i] = v[i];
        e = {v[0], v[0] & v[1], v[0] | v[1], ~v[2]};
        exp_logic_q.push_back(e);
    endtask

    task automatic check_logic(input string name);
        logic [3:0] e, a;
        #0.1;
        e = exp_logic_q.pop_front();
        a = {o0_a, o_and_a, o_or_a, o_not_a};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: outputs {in0,and,or,not2} got %b expected %b", name, a, e);
        end
        a = {o0_c, o_and_c, o_or_c, o_not_c};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s_def: outputs {in0,and,or,not2} got %b expected %b", name, a, e);
        end
    endtask

    // One rising edge: push the model's expectation, then compare after the edge.
    task automatic step(input logic r);
        bit e4, e1;
        rst = r;
        if (r) begin
            k4 = 0; k1 = 0;
        end else begin
            k4++; k1++;
        end
        exp4_q.push_back(((k4 / 4) % 2) == 1);
        exp1_q.push_back((k1 % 2) == 1);
        @(posedge clk_p);
        #1;
        cyc++;
        e4 = exp4_q.pop_front();
        e1 = exp1_q.pop_front();
        n_tests++;
        if (blink_4 !== e4) begin
            n_fail++;
            $display("FAIL div4 cycle %0d: got %b expected %b", cyc, blink_4, e4);
        end
        n_tests++;
        if (blink_1 !== e1) begin
            n_fail++;
            $display("FAIL div1 cycle %0d: got %b expected %b", cyc, blink_1, e1);
        end
        n_tests++;
        if (blink_def !== 1'b0) begin
            n_fail++;
            $display("FAIL div_default cycle %0d: got %b expected 0", cyc, blink_def);
        end
    endtask

    task automatic test_reset();
        drive_in(5'b00000);
        check_logic("reset_inputs_zero");
        for (int i = 0; i < 3; i++) step(1'b1);
    endtask

    task automatic test_logic_sweep();
        logic [4:0] v;
        for (int i = 0; i < 8; i++) begin
            v = {2'($urandom_range(0, 3)), 3'(i)};
            drive_in(v);
            check_logic("truth_table");
            for (int j = 0; j < 4; j++) begin
                v[4:3] = 2'(j);
                drive_in(v);
                check_logic("spare_inputs");
            end
        end
    endtask

    task automatic test_divider();
        int last_rise = -1;
        logic prev = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1);
        prev = blink_4;
        for (int i = 0; i < 26; i++) begin
            step(1'b0);
            if (blink_4 === 1'b1 && prev === 1'b0) begin
                if (last_rise < 0) begin
                    n_tests++;
                    if (i + 1 != 4) begin
                        n_fail++;
                        $display("FAIL first_rise: got edge %0d expected edge 4", i + 1);
                    end
                end else begin
                    n_tests++;
                    if (i - last_rise != 8) begin
                        n_fail++;
                        $display("FAIL period: got %0d cycles expected 8", i - last_rise);
                    end
                end
                last_rise = i;
            end
            prev = blink_4;
        end
    endtask

    task automatic test_reset_mid_count();
        for (int i = 0; i < 2; i++) step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        n_tests++;
        if (blink_4 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_count_setup: got %b expected 1", blink_4);
        end
        step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 9; i++) step(1'b0);
    endtask

    initial begin
        test_reset();
        test_logic_sweep();
        test_divider();
        test_reset_mid_count();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
